// File: rtl/msg_counter_bank_if.sv
// Avalon-MM register-access interface used by the debug register bank.
// Fixed-latency slave: no waitrequest, one readdatavalid per accepted read.
`timescale 1ns/1ps
interface avalon_mm_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/msg_counter_bank.sv
// Per-channel message counters with scratch, sticky overflow status and
// atomic snapshot, exposed as a fixed-latency Avalon-MM register bank.
`timescale 1ns/1ps
module msg_counter_bank #(
    parameter int ADDR_WIDTH   = 16,
    parameter int ADDR_BASE    = 'h400,
    parameter int ADDR_STEP    = 'h2,
    parameter int NUM_CHANNELS = 4,
    parameter int COUNTER_SIZE = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SCRATCH  = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] msg_enter,
    output logic                    overflow_irq,
    avalon_mm_if.slave              reg_mm
);
    localparam int IDX_CTRL     = 0;
    localparam int IDX_STATUS   = 1;
    localparam int IDX_SNAP_CMD = 2;
    localparam int SCRATCH_BASE = 3;
    localparam int LIVE_BASE    = SCRATCH_BASE + NUM_SCRATCH;
    localparam int SNAP_BASE    = LIVE_BASE + NUM_CHANNELS;
    localparam int NUM_REGS     = SNAP_BASE + NUM_CHANNELS;

    logic                    sat_mode;
    logic                    freeze;
    logic [NUM_CHANNELS-1:0] irq_en;
    logic [NUM_CHANNELS-1:0] status;
    logic [COUNTER_SIZE-1:0] live_cnt [NUM_CHANNELS];
    logic [COUNTER_SIZE-1:0] snap_cnt [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   scratch  [NUM_SCRATCH];

    logic                    reg_hit;
    int                      reg_idx;
    logic                    wr_en;
    logic [NUM_CHANNELS-1:0] ovf_set;
    logic [NUM_CHANNELS-1:0] w1c_mask;
    logic [DATA_WIDTH-1:0]   rd_data;

    logic [READ_LATENCY-1:0] rd_vld_q;
    logic [DATA_WIDTH-1:0]   rd_data_q [READ_LATENCY];

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        reg_hit = 1'b0;
        reg_idx = 0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (reg_mm.address == ADDR_WIDTH'(ADDR_BASE + ADDR_STEP * k)) begin
                reg_hit = 1'b1;
                reg_idx = k;
            end
        end
    end

    assign wr_en = reg_mm.write && reg_hit;

    // Overflow is the increment attempt at all-ones, in either mode.
    always_comb begin
        ovf_set  = '0;
        w1c_mask = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ovf_set[i] = !freeze && msg_enter[i] && (&live_cnt[i]);
        end
        if (wr_en && reg_idx == IDX_STATUS) begin
            w1c_mask = reg_mm.writedata[NUM_CHANNELS-1:0];
        end
    end

    // Read mux sees pre-update state, so a same-cycle write is not visible.
    always_comb begin
        rd_data = '0;
        if (reg_hit) begin
            if (reg_idx == IDX_CTRL) begin
                rd_data[0]                 = sat_mode;
                rd_data[1]                 = freeze;
                rd_data[16 +: NUM_CHANNELS] = irq_en;
            end
            if (reg_idx == IDX_STATUS) begin
                rd_data[NUM_CHANNELS-1:0] = status;
            end
            for (int j = 0; j < NUM_SCRATCH; j++) begin
                if (reg_idx == SCRATCH_BASE + j) rd_data = scratch[j];
            end
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (reg_idx == LIVE_BASE + i) rd_data = DATA_WIDTH'(live_cnt[i]);
                if (reg_idx == SNAP_BASE + i) rd_data = DATA_WIDTH'(snap_cnt[i]);
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_mode     <= 1'b0;
            freeze       <= 1'b0;
            irq_en       <= '0;
            status       <= '0;
            overflow_irq <= 1'b0;
            // NOTE: these arrays are small flop banks, not RAM, so they reset.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                live_cnt[i] <= '0;
                snap_cnt[i] <= '0;
            end
            for (int j = 0; j < NUM_SCRATCH; j++) scratch[j] <= '0;
        end else begin
            if (wr_en && reg_idx == IDX_CTRL) begin
                sat_mode <= reg_mm.writedata[0];
                freeze   <= reg_mm.writedata[1];
                irq_en   <= reg_mm.writedata[16 +: NUM_CHANNELS];
            end
            status       <= (status & ~w1c_mask) | ovf_set;
            overflow_irq <= |(status & irq_en);

            for (int j = 0; j < NUM_SCRATCH; j++) begin
                if (wr_en && reg_idx == SCRATCH_BASE + j) scratch[j] <= reg_mm.writedata;
            end

            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (wr_en && reg_idx == IDX_SNAP_CMD) snap_cnt[i] <= live_cnt[i];
                if (wr_en && reg_idx == LIVE_BASE + i) begin
                    live_cnt[i] <= '0;
                end else if (!freeze && msg_enter[i] && !(sat_mode && (&live_cnt[i]))) begin
                    live_cnt[i] <= live_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Fixed-latency response pipe; data is forced to 0 on idle stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= '0;
            for (int s = 0; s < READ_LATENCY; s++) rd_data_q[s] <= '0;
        end else begin
            rd_vld_q[0]  <= reg_mm.read;
            rd_data_q[0] <= reg_mm.read ? rd_data : '0;
            for (int s = 1; s < READ_LATENCY; s++) begin
                rd_vld_q[s]  <= rd_vld_q[s-1];
                rd_data_q[s] <= rd_data_q[s-1];
            end
        end
    end

    assign reg_mm.readdatavalid = rd_vld_q[READ_LATENCY-1];
    assign reg_mm.readdata      = rd_data_q[READ_LATENCY-1];

endmodule

// File: tb/tb_msg_counter_bank.sv
// Scoreboard bench for msg_counter_bank: three instances cover the default,
// 4-bit counter and READ_LATENCY=3 configurations.
`timescale 1ns/1ps
module tb_msg_counter_bank;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] me_a, me_b, me_c;
    logic       irq_a, irq_b, irq_c;
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq [$];

    avalon_mm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_a ();
    avalon_mm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_b ();
    avalon_mm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_c ();

    msg_counter_bank dut_a (
        .clk(clk), .rst_n(rst_n), .msg_enter(me_a), .overflow_irq(irq_a), .reg_mm(bus_a)
    );
    msg_counter_bank #(.COUNTER_SIZE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .msg_enter(me_b), .overflow_irq(irq_b), .reg_mm(bus_b)
    );
    msg_counter_bank #(.READ_LATENCY(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .msg_enter(me_c), .overflow_irq(irq_c), .reg_mm(bus_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ra(input int k);
        return 16'(32'h400 + 2 * k);
    endfunction

    task automatic clear_bus();
        bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.address = '0; bus_a.writedata = '0;
        bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.address = '0; bus_b.writedata = '0;
        bus_c.read = 1'b0; bus_c.write = 1'b0; bus_c.address = '0; bus_c.writedata = '0;
        me_a = '0; me_b = '0; me_c = '0;
    endtask

    // One bus cycle on instance sel; a read pushes its expected response.
    task automatic bus_cycle(input int sel, input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [31:0] wdata, input logic [3:0] me,
                             input logic [31:0] exp, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        clear_bus();
        case (sel)
            0: begin bus_a.read = rd; bus_a.write = wr; bus_a.address = addr; bus_a.writedata = wdata; me_a = me; end
            1: begin bus_b.read = rd; bus_b.write = wr; bus_b.address = addr; bus_b.writedata = wdata; me_b = me; end
            default: begin bus_c.read = rd; bus_c.write = wr; bus_c.address = addr; bus_c.writedata = wdata; me_c = me; end
        endcase
        if (rd) begin
            e.sel  = sel;
            e.tag  = tag;
            e.data = exp;
            e.due  = cyc + ((sel == 2) ? 3 : 1);
            sbq.push_back(e);
        end
    endtask

    task automatic rd_reg(input int sel, input int k, input logic [31:0] exp, input string tag);
        bus_cycle(sel, 1'b1, 1'b0, ra(k), 32'h0, 4'h0, exp, tag);
    endtask

    task automatic wr_reg(input int sel, input int k, input logic [31:0] wdata);
        bus_cycle(sel, 1'b0, 1'b1, ra(k), wdata, 4'h0, 32'h0, "");
    endtask

    task automatic pulse(input int sel, input logic [3:0] me, input int n);
        for (int i = 0; i < n; i++) bus_cycle(sel, 1'b0, 1'b0, 16'h0, 32'h0, me, 32'h0, "");
    endtask

    task automatic idle(input int n);
        pulse(0, 4'h0, n);
    endtask

    task automatic mon(input int sel, input logic v, input logic [31:0] d);
        int idx;
        idx = -1;
        for (int i = 0; i < sbq.size(); i++) begin
            if (idx < 0 && sbq[i].sel == sel) idx = i;
        end
        if (v) begin
            if (idx < 0) begin
                check($sformatf("unexpected_valid_%0d", sel), 32'(v), 32'h0);
            end else begin
                check(sbq[idx].tag, d, sbq[idx].data);
                check({sbq[idx].tag, "_latency"}, 32'(cyc), 32'(sbq[idx].due));
                sbq.delete(idx);
            end
        end else begin
            if (d !== '0) check($sformatf("idle_readdata_%0d", sel), d, 32'h0);
            if (idx >= 0 && sbq[idx].due < cyc) begin
                check({sbq[idx].tag, "_missing_valid"}, 32'(v), 32'h1);
                sbq.delete(idx);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.readdatavalid, bus_a.readdata);
        mon(1, bus_b.readdatavalid, bus_b.readdata);
        mon(2, bus_c.readdatavalid, bus_c.readdata);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_bus();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("irq_a_reset", 32'(irq_a), 32'h0);
        check("irq_b_reset", 32'(irq_b), 32'h0);

        // Every mapped index of the default instance reads 0 after reset.
        for (int k = 0; k < 13; k++) rd_reg(0, k, 32'h0, $sformatf("a_reset_idx%0d", k));

        pulse(0, 4'b0101, 5);
        rd_reg(0, 5, 32'd5, "a_cnt0");
        rd_reg(0, 6, 32'd0, "a_cnt1");
        rd_reg(0, 7, 32'd5, "a_cnt2");
        rd_reg(0, 8, 32'd0, "a_cnt3");

        // Snapshot taken in the same cycle as an increment on channel 2.
        pulse(0, 4'b0100, 4);
        bus_cycle(0, 1'b0, 1'b1, ra(2), 32'h0, 4'b0100, 32'h0, "");
        rd_reg(0, 11, 32'd9,  "a_snap2_pre_inc");
        rd_reg(0, 7,  32'd10, "a_live2_post_inc");
        rd_reg(0, 9,  32'd5,  "a_snap0");
        rd_reg(0, 2,  32'd0,  "a_snapcmd_reads0");

        bus_cycle(0, 1'b0, 1'b1, ra(7), 32'h0, 4'b0100, 32'h0, "");
        rd_reg(0, 7, 32'd0, "a_clear_wins");

        wr_reg(0, 0, 32'h2);
        pulse(0, 4'b0001, 3);
        rd_reg(0, 5, 32'd5, "a_freeze_hold");
        rd_reg(0, 0, 32'h2, "a_ctrl_readback");
        wr_reg(0, 0, 32'h0);
        pulse(0, 4'b0001, 1);
        rd_reg(0, 5, 32'd6, "a_unfreeze_inc");

        bus_cycle(0, 1'b1, 1'b1, ra(3), 32'h1234, 4'h0, 32'h0, "a_rw_same_cycle_old");
        rd_reg(0, 3, 32'h1234, "a_scratch0_new");
        wr_reg(0, 4, 32'hDEAD_BEEF);
        rd_reg(0, 4, 32'hDEAD_BEEF, "a_scratch1_full");
        wr_reg(0, 11, 32'hFFFF);
        rd_reg(0, 11, 32'd9, "a_snap_readonly");

        // 4-bit counters: wrap, then saturate.
        pulse(1, 4'b0010, 17);
        rd_reg(1, 6, 32'd1, "b_wrap_cnt");
        rd_reg(1, 1, 32'h2, "b_wrap_status");
        wr_reg(1, 1, 32'h2);
        rd_reg(1, 1, 32'h0, "b_w1c_clear");
        wr_reg(1, 6, 32'h0);
        wr_reg(1, 0, 32'h1);
        pulse(1, 4'b0010, 17);
        rd_reg(1, 6, 32'd15, "b_sat_cnt");
        rd_reg(1, 1, 32'h2,  "b_sat_status");

        wr_reg(1, 1, 32'h2);
        wr_reg(1, 0, 32'h0002_0001);
        @(negedge clk);
        check("b_irq_idle", 32'(irq_b), 32'h0);
        pulse(1, 4'b0010, 1);
        @(negedge clk);
        check("b_irq_before_status", 32'(irq_b), 32'h0);
        idle(1);
        @(negedge clk);
        check("b_irq_same_cycle_as_status", 32'(irq_b), 32'h0);
        idle(1);
        @(negedge clk);
        check("b_irq_rise", 32'(irq_b), 32'h1);
        rd_reg(1, 1, 32'h2, "b_irq_status");

        bus_cycle(1, 1'b0, 1'b1, ra(1), 32'h2, 4'b0010, 32'h0, "");
        rd_reg(1, 1, 32'h2, "b_set_beats_w1c");
        wr_reg(1, 1, 32'h2);
        rd_reg(1, 1, 32'h0, "b_status_cleared");
        @(negedge clk);
        check("b_irq_fall_delay", 32'(irq_b), 32'h1);
        idle(1);
        @(negedge clk);
        check("b_irq_fall", 32'(irq_b), 32'h0);

        // READ_LATENCY=3: four pipelined reads.
        wr_reg(2, 3, 32'hAA);
        pulse(2, 4'b0001, 7);
        rd_reg(2, 3, 32'hAA, "c_scratch0");
        bus_cycle(2, 1'b1, 1'b0, 16'h0401, 32'h0, 4'h0, 32'h0, "c_unmapped");
        rd_reg(2, 2, 32'h0, "c_snapcmd");
        rd_reg(2, 5, 32'd7, "c_cnt0");
        idle(6);

        // Reset during an in-flight read: the response is dropped.
        rd_reg(2, 5, 32'd7, "c_dropped");
        @(posedge clk);
        #1;
        clear_bus();
        rst_n = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        rd_reg(2, 5, 32'd0, "c_cnt0_after_reset");
        rd_reg(0, 3, 32'd0, "a_scratch0_after_reset");
        rd_reg(1, 0, 32'd0, "b_ctrl_after_reset");
        @(negedge clk);
        check("b_irq_after_reset", 32'(irq_b), 32'h0);

        idle(1);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) check("scoreboard_drain", 32'(sbq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
